steak_grill_controller: RTL and testbench
=========================================

Name: steak_grill_controller

Overview:
Game-side controller for one grill slot. It drives the steak-show timer, so it is the initiator on the timer's re-arm/pulse interface. It picks a random show delay and releases the timer. On the timer's show pulse it places a steak, then tracks cooking time (raw → cooked → burnt). It resolves the player's serve action into score or penalty pulses for the scoring/VGA logic, then re-arms the timer for the next steak.

Parameters:
CLK_HZ, 50000000, clock cycles per second (override to a small value in simulation)
COOK_SECS, 3, whole seconds on grill until cooked (≥1, ≤14)
BURN_SECS, 6, whole seconds on grill until burnt (>COOK_SECS, ≤15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin game; single-cycle pulse
stop  in  1  end game; single-cycle pulse
serve_key  in  1  player serve key, level; edge-detected internally
steakShow  in  1  one-cycle show pulse from the steak-show timer
steak_show_resetn  out  1  timer hold: 1 = timer held at zero, 0 = timer runs
steakShowTime  out  3  show delay in seconds to the timer; always 1..7
steak_visible  out  1  steak drawn on grill
doneness  out  2  0 none, 1 raw, 2 cooked, 3 burnt
score_pulse  out  1  one cycle: cooked steak served
penalty_pulse  out  1  one cycle: raw steak served
burn_pulse  out  1  one cycle: steak became burnt

Behaviour:
- All outputs registered. Reset values:
  - state = IDLE, steak_show_resetn = 1, steakShowTime = 1
  - steak_visible, doneness, all pulses = 0
  - lfsr = 8'hA5, prescaler = 0, cook_secs = 0, serve_q = 0
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle, never reset except by reset.
- Delay load: steakShowTime ← lfsr[2:0], with 0 mapped to 1.
- serve_evt = serve_key & ~serve_q, where serve_q is serve_key delayed one cycle.
- Prescaler counts 0..CLK_HZ-1 only in RAW/COOKED/BURNT. sec_tick when prescaler == CLK_HZ-1.
- cook_secs is 4-bit, increments on sec_tick, saturates at 15. Prescaler and cook_secs clear on entry to RAW.
- States:
  - IDLE: steak_show_resetn = 1, steak_visible = 0. On start → WAIT_SHOW; load delay; steak_show_resetn = 0 from the next cycle.
  - WAIT_SHOW: steak_show_resetn = 0. serve_evt is ignored. On steakShow → RAW.
  - RAW: steak_show_resetn = 1, steak_visible = 1, doneness = 1.
    - serve_evt → CLEANUP with penalty_pulse.
    - cook_secs reaching COOK_SECS → COOKED.
  - COOKED: doneness = 2.
    - serve_evt → CLEANUP with score_pulse.
    - cook_secs reaching BURN_SECS → BURNT.
  - BURNT: doneness = 3; burn_pulse on the entry cycle only. serve_evt → CLEANUP with no score (discard).
  - CLEANUP (1 cycle): steak_visible = 0, doneness = 0, load a new delay → WAIT_SHOW.
- Latency:
  - steakShow in cycle N → steak_visible = 1 and steak_show_resetn = 1 in N+1.
  - serve_evt in cycle N → pulse and steak_visible = 0 in N+1 → steak_show_resetn = 0 in N+2.
- Boundaries:
  - serve_evt in the same cycle as a doneness transition is judged on the current state (pre-transition).
  - steakShow outside WAIT_SHOW is ignored.
  - stop, in any state, has priority over all events → IDLE next cycle, no pulses, timer held.
  - start while not in IDLE is ignored.
  - Reset mid-operation returns all values to reset values in the next cycle.
  - steakShowTime is never 0, so the timer never fires at count zero.

Test Plan:
1. reset 3 cycles, CLK_HZ=10 → steak_show_resetn=1, steakShowTime=1, all pulses 0; start → WAIT_SHOW, steak_show_resetn=0 one cycle later, steakShowTime in 1..7.
2. steakShow pulse at cycle N → steak_visible=1, doneness=1, steak_show_resetn=1 at N+1; doneness=2 after 30 cycles (COOK_SECS=3).
3. Serve rising edge in COOKED → score_pulse high exactly 1 cycle; steak_visible=0; steak_show_resetn=0 two cycles after the edge; new steakShowTime in 1..7.
4. Serve in RAW → penalty_pulse 1 cycle, no score_pulse; holding serve_key high for 50 cycles yields only one event.
5. No serve: doneness=3 and one burn_pulse at 60 cycles after RAW entry; later serve → CLEANUP with no score or penalty.
6. stop during COOKED with a simultaneous serve edge → IDLE, no score_pulse, steak_visible=0, steak_show_resetn=1; steakShow pulse while in IDLE → no state change.

Source files
------------

// File: rtl/steak_grill_controller.sv
// Grill-slot controller for the steak game.
// Arms the steak-show timer with a pseudo-random delay and places a steak when
// the timer fires. It then tracks cooking time (raw -> cooked -> burnt) and
// turns the player's serve into score or penalty pulses before re-arming.
module steak_grill_controller #(
   parameter int CLK_HZ    = 50000000,
   parameter int COOK_SECS = 3,
   parameter int BURN_SECS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       serve_key,
   input  logic       steakShow,
   output logic       steak_show_resetn,
   output logic [2:0] steakShowTime,
   output logic       steak_visible,
   output logic [1:0] doneness,
   output logic       score_pulse,
   output logic       penalty_pulse,
   output logic       burn_pulse
);

   localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRE_MAX   = PW'(CLK_HZ - 1);
   localparam logic [3:0]     COOK_LIM  = 4'(COOK_SECS);
   localparam logic [3:0]     BURN_LIM  = 4'(BURN_SECS);
   localparam logic [7:0]     LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SHOW = 3'd1,
      RAW       = 3'd2,
      COOKED    = 3'd3,
      BURNT     = 3'd4,
      CLEANUP   = 3'd5
   } state_t;

   // Fibonacci LFSR, taps 8,6,5,4.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // The timer must never be given a zero delay, so 0 maps to 1.
   function automatic logic [2:0] delay_map(input logic [2:0] v);
      return (v == 3'd0) ? 3'd1 : v;
   endfunction

   // Seconds counter saturates so a forgotten steak cannot wrap back to raw.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'd15) ? 4'd15 : v + 4'd1;
   endfunction

   state_t        state;
   state_t        state_next;
   logic [7:0]    lfsr;
   logic [PW-1:0] prescaler;
   logic [3:0]    cook_secs;
   logic [3:0]    cook_inc;
   logic          serve_q;
   logic          serve_evt;
   logic          cooking;
   logic          sec_tick;
   logic          load_delay;
   logic          resetn_d;
   logic          visible_d;
   logic [1:0]    doneness_d;
   logic          score_d;
   logic          penalty_d;
   logic          burn_d;

   assign serve_evt = serve_key & ~serve_q;
   assign cooking   = (state == RAW) || (state == COOKED) || (state == BURNT);
   assign sec_tick  = cooking && (prescaler == PRE_MAX);
   assign cook_inc  = sat_inc4(cook_secs);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic plus the next values of every registered output.
   // A serve arriving on the same cycle as a doneness change is judged
   // against the current state, so serve is tested before the time limits.
   always_comb begin
      state_next = state;
      load_delay = 1'b0;
      score_d    = 1'b0;
      penalty_d  = 1'b0;
      burn_d     = 1'b0;
      if (stop) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next = WAIT_SHOW;
                  load_delay = 1'b1;
               end
            end
            WAIT_SHOW: begin
               if (steakShow) state_next = RAW;
            end
            RAW: begin
               if (serve_evt) begin
                  state_next = CLEANUP;
                  penalty_d  = 1'b1;
               end else if (sec_tick && (cook_inc == COOK_LIM)) begin
                  state_next = COOKED;
               end
            end
            COOKED: begin
               if (serve_evt) begin
                  state_next = CLEANUP;
                  score_d    = 1'b1;
               end else if (sec_tick && (cook_inc == BURN_LIM)) begin
                  state_next = BURNT;
                  burn_d     = 1'b1;
               end
            end
            BURNT: begin
               if (serve_evt) state_next = CLEANUP;
            end
            CLEANUP: begin
               state_next = WAIT_SHOW;
               load_delay = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end

      resetn_d  = (state_next != WAIT_SHOW);
      visible_d = (state_next == RAW) || (state_next == COOKED) ||
                  (state_next == BURNT);
      case (state_next)
         RAW:     doneness_d = 2'd1;
         COOKED:  doneness_d = 2'd2;
         BURNT:   doneness_d = 2'd3;
         default: doneness_d = 2'd0;
      endcase
   end

   // Output registers, so every output changes exactly with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         steak_show_resetn <= 1'b1;
         steakShowTime     <= 3'd1;
         steak_visible     <= 1'b0;
         doneness          <= 2'd0;
         score_pulse       <= 1'b0;
         penalty_pulse     <= 1'b0;
         burn_pulse        <= 1'b0;
      end else begin
         steak_show_resetn <= resetn_d;
         if (load_delay) steakShowTime <= delay_map(lfsr[2:0]);
         steak_visible     <= visible_d;
         doneness          <= doneness_d;
         score_pulse       <= score_d;
         penalty_pulse     <= penalty_d;
         burn_pulse        <= burn_d;
      end
   end

   // Free-running random source and serve-key edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr    <= LFSR_SEED;
         serve_q <= 1'b0;
      end else begin
         lfsr    <= lfsr_step(lfsr);
         serve_q <= serve_key;
      end
   end

   // Time on the grill: restarts when a steak is placed, runs only while cooking.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         cook_secs <= 4'd0;
      end else if ((state == WAIT_SHOW) && (state_next == RAW)) begin
         prescaler <= '0;
         cook_secs <= 4'd0;
      end else if (cooking) begin
         if (sec_tick) begin
            prescaler <= '0;
            cook_secs <= cook_inc;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_steak_grill_controller.sv
// Bench for steak_grill_controller: directed game sequence followed by random
// play. A game-level model predicts every cycle's outputs into a queue; a
// separate monitor pops and compares against the DUT.
module tb_steak_grill_controller;

   localparam int HZ = 10;
   localparam int CK = 3;
   localparam int BS = 6;

   logic       clk = 1'b0;
   logic       reset, start, stop, serve_key, steakShow;
   logic       steak_show_resetn;
   logic [2:0] steakShowTime;
   logic       steak_visible;
   logic [1:0] doneness;
   logic       score_pulse, penalty_pulse, burn_pulse;

   steak_grill_controller #(.CLK_HZ(HZ), .COOK_SECS(CK), .BURN_SECS(BS)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .serve_key(serve_key), .steakShow(steakShow),
      .steak_show_resetn(steak_show_resetn), .steakShowTime(steakShowTime),
      .steak_visible(steak_visible), .doneness(doneness),
      .score_pulse(score_pulse), .penalty_pulse(penalty_pulse),
      .burn_pulse(burn_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rn;
      logic [2:0] st;
      logic       vis;
      logic [1:0] dn;
      logic       sc;
      logic       pe;
      logic       bu;
   } obs_t;

   typedef enum {P_IDLE, P_WAIT, P_GRILL, P_CLEAN} phase_t;

   obs_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     cycle  = 0;
   int     n_score = 0, n_pen = 0, n_burn = 0;
   logic   m_on = 1'b0;

   // Game-level reference: time on grill in cycles, doneness by thresholds.
   phase_t     m_phase;
   int         m_t;
   logic [7:0] m_lfsr;
   logic       m_prev;
   logic [2:0] m_show;

   function automatic logic [1:0] level(input int t);
      if (t < CK * HZ) return 2'd1;
      if (t < BS * HZ) return 2'd2;
      return 2'd3;
   endfunction

   initial begin
      forever begin
         obs_t o;
         logic evt, load;
         logic [1:0] cur;
         @(posedge clk);
         cycle++;
         o = '0;
         if (reset) begin
            m_on    = 1'b1;
            m_phase = P_IDLE;
            m_t     = 0;
            m_lfsr  = 8'hA5;
            m_prev  = 1'b0;
            m_show  = 3'd1;
         end else if (m_on) begin
            evt    = serve_key && !m_prev;
            m_prev = serve_key;
            cur    = level(m_t);
            load   = 1'b0;
            if (stop) begin
               m_phase = P_IDLE;
            end else begin
               case (m_phase)
                  P_IDLE: if (start) begin m_phase = P_WAIT; load = 1'b1; end
                  P_WAIT: if (steakShow) begin m_phase = P_GRILL; m_t = 0; end
                  P_GRILL: begin
                     if (evt) begin
                        o.pe    = (cur == 2'd1);
                        o.sc    = (cur == 2'd2);
                        m_phase = P_CLEAN;
                     end else begin
                        m_t++;
                        o.bu = (m_t == BS * HZ);
                     end
                  end
                  default: begin m_phase = P_WAIT; load = 1'b1; end
               endcase
            end
            if (load) m_show = (m_lfsr[2:0] == 3'd0) ? 3'd1 : m_lfsr[2:0];
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         end
         if (m_on) begin
            o.rn  = (m_phase != P_WAIT);
            o.st  = m_show;
            o.vis = (m_phase == P_GRILL);
            o.dn  = (m_phase == P_GRILL) ? level(m_t) : 2'd0;
            exp_q.push_back(o);
         end
      end
   end

   // Monitor: samples just after each active edge and checks against the queue.
   initial begin
      forever begin
         obs_t a, e;
         @(posedge clk);
         #1;
         if (m_on) begin
            a = '{steak_show_resetn, steakShowTime, steak_visible, doneness,
                  score_pulse, penalty_pulse, burn_pulse};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty cycle %0d: no expected record", cycle);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL outputs cycle %0d: got rn=%0b st=%0d vis=%0b dn=%0d sc=%0b pe=%0b bu=%0b, expected rn=%0b st=%0d vis=%0b dn=%0d sc=%0b pe=%0b bu=%0b",
                           cycle, a.rn, a.st, a.vis, a.dn, a.sc, a.pe, a.bu,
                           e.rn, e.st, e.vis, e.dn, e.sc, e.pe, e.bu);
               end
            end
            checks++;
            if (steakShowTime == 3'd0 || $isunknown(steakShowTime)) begin
               errors++;
               $display("FAIL show_time_range cycle %0d: got %0d, expected 1..7",
                        cycle, steakShowTime);
            end
            if (score_pulse === 1'b1)   n_score++;
            if (penalty_pulse === 1'b1) n_pen++;
            if (burn_pulse === 1'b1)    n_burn++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic pulse_show();
      steakShow = 1'b1; step(1); steakShow = 1'b0;
   endtask

   initial begin
      int rate;
      reset = 1'b1; start = 1'b0; stop = 1'b0; serve_key = 1'b0; steakShow = 1'b0;
      step(3);
      reset = 1'b0;
      step(2);
      // game start, then a steak served cooked
      pulse_start(); step(4);
      pulse_show();  step(35);
      serve_key = 1'b1; step(2); serve_key = 1'b0; step(4);
      // served raw, key held long: one event only
      pulse_show();  step(5);
      serve_key = 1'b1; step(50); serve_key = 1'b0; step(3);
      // left to burn, then discarded
      pulse_show();  step(70);
      serve_key = 1'b1; step(1); serve_key = 1'b0; step(3);
      // stop with a simultaneous serve edge while cooked
      pulse_show();  step(35);
      stop = 1'b1; serve_key = 1'b1; step(1);
      stop = 1'b0; serve_key = 1'b0; step(2);
      // show pulse while idle is ignored
      pulse_show();  step(5);
      pulse_start(); step(3);
      // random play
      rate = 40;
      for (int i = 0; i < 15000; i++) begin
         if (i % 500 == 0) begin
            case ($urandom_range(0, 2))
               0:       rate = 8;
               1:       rate = 40;
               default: rate = 120;
            endcase
         end
         reset     = ($urandom_range(0, 2999) == 0);
         start     = ($urandom_range(0, 29) == 0);
         stop      = ($urandom_range(0, 399) == 0);
         steakShow = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, rate - 1) == 0) serve_key = ~serve_key;
         step(1);
      end
      reset = 1'b0; start = 1'b0; stop = 1'b0; steakShow = 1'b0; serve_key = 1'b0;
      step(3);
      checks++;
      if (n_score == 0) begin
         errors++;
         $display("FAIL score_seen: got %0d score pulses, expected at least 1", n_score);
      end
      checks++;
      if (n_pen == 0) begin
         errors++;
         $display("FAIL penalty_seen: got %0d penalty pulses, expected at least 1", n_pen);
      end
      checks++;
      if (n_burn == 0) begin
         errors++;
         $display("FAIL burn_seen: got %0d burn pulses, expected at least 1", n_burn);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
